// File: rtl/trap_arbiter_if.sv
// Trap arbiter bus: commit-stage exception/interrupt inputs toward the arbiter
// and the presented trap toward the exception handler.
interface trap_arbiter_if #(
   parameter int XLEN = 64
);
   logic [15:0]     exc_valid_i;
   logic [XLEN-1:0] exc_pc_i;
   logic [XLEN-1:0] exc_tval_i;
   logic [2:0]      irq_i;
   logic [2:0]      mie_i;
   logic            mstatus_mie_i;
   logic            trap_ready_i;
   logic            mret_i;
   logic            trap_taken_o;
   logic [XLEN-1:0] trap_cause_o;
   logic [XLEN-1:0] trap_pc_o;
   logic [XLEN-1:0] trap_tval_o;
   logic            busy_o;

   modport slave (
      input  exc_valid_i, exc_pc_i, exc_tval_i, irq_i, mie_i, mstatus_mie_i,
      input  trap_ready_i, mret_i,
      output trap_taken_o, trap_cause_o, trap_pc_o, trap_tval_o, busy_o
   );

   modport master (
      output exc_valid_i, exc_pc_i, exc_tval_i, irq_i, mie_i, mstatus_mie_i,
      output trap_ready_i, mret_i,
      input  trap_taken_o, trap_cause_o, trap_pc_o, trap_tval_o, busy_o
   );
endinterface

// File: rtl/trap_arbiter.sv
// Picks the highest-priority trap, presents it to the handler until accepted,
// then blocks further traps until mret.
module trap_arbiter #(
   parameter int XLEN = 64
) (
   input  logic           clock_i,
   input  logic           reset_i,
   trap_arbiter_if.slave  bus_if
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESENT    = 2'd1,
      ST_IN_SERVICE = 2'd2
   } state_t;

   // Exception codes, highest priority first.
   localparam logic [3:0] EXC_ORDER [16] = '{
      4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9, 4'd11,
      4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5, 4'd10, 4'd14
   };

   function automatic logic [3:0] f_exc_code(input logic [15:0] flags);
      logic [3:0] code;
      code = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (flags[EXC_ORDER[i]]) begin
            code = EXC_ORDER[i];
         end
      end
      return code;
   endfunction

   state_t          r_state;
   logic            r_taken;
   logic            r_busy;
   logic [XLEN-1:0] r_cause;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_tval;

   state_t          w_state_next;
   logic            w_capture;
   logic [2:0]      w_irq_en;
   logic [3:0]      w_irq_code;
   logic            w_is_irq;
   logic            w_event;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_tval;

   // Interrupt qualification and MEI > MSI > MTI selection
   always_comb begin
      w_irq_en   = bus_if.irq_i & bus_if.mie_i & {3{bus_if.mstatus_mie_i}};
      w_is_irq   = |w_irq_en;
      w_event    = w_is_irq | (|bus_if.exc_valid_i);
      w_irq_code = 4'd0;
      if (w_irq_en[2]) begin
         w_irq_code = 4'd11;
      end else if (w_irq_en[0]) begin
         w_irq_code = 4'd3;
      end else if (w_irq_en[1]) begin
         w_irq_code = 4'd7;
      end else begin
         w_irq_code = 4'd0;
      end
   end

   // Candidate cause/tval; an interrupt always beats a same-cycle exception
   always_comb begin
      w_cause = {XLEN{1'b0}};
      w_tval  = {XLEN{1'b0}};
      if (w_is_irq) begin
         w_cause = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
         w_tval  = {XLEN{1'b0}};
      end else begin
         w_cause = {1'b0, {(XLEN-5){1'b0}}, f_exc_code(bus_if.exc_valid_i)};
         w_tval  = bus_if.exc_tval_i;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_event) begin
               w_state_next = ST_PRESENT;
               w_capture    = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (bus_if.trap_ready_i) begin
               w_state_next = ST_IN_SERVICE;
            end else begin
               w_state_next = ST_PRESENT;
            end
         end
         ST_IN_SERVICE: begin
            if (bus_if.mret_i) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_IN_SERVICE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; trap fields only load on capture
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
         r_taken <= 1'b0;
         r_busy  <= 1'b0;
         r_cause <= {XLEN{1'b0}};
         r_pc    <= {XLEN{1'b0}};
         r_tval  <= {XLEN{1'b0}};
      end else begin
         r_state <= w_state_next;
         r_taken <= (w_state_next == ST_PRESENT);
         r_busy  <= (w_state_next == ST_PRESENT) || (w_state_next == ST_IN_SERVICE);
         if (w_capture) begin
            r_cause <= w_cause;
            r_pc    <= bus_if.exc_pc_i;
            r_tval  <= w_tval;
         end
      end
   end

   assign bus_if.trap_taken_o = r_taken;
   assign bus_if.busy_o       = r_busy;
   assign bus_if.trap_cause_o = r_cause;
   assign bus_if.trap_pc_o    = r_pc;
   assign bus_if.trap_tval_o  = r_tval;

endmodule

// File: tb/tb_trap_arbiter.sv
// Scoreboard bench for trap_arbiter: stimulus queues expected traps, a monitor
// pops them at each accepted handshake.
module tb_trap_arbiter;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] pc;
      logic [63:0] tval;
   } trap_t;

   logic   clock;
   logic   reset_i;
   int     n_checks = 0;
   int     n_pass   = 0;
   trap_t  sb_q[$];

   trap_arbiter_if #(.XLEN(64)) bus ();

   trap_arbiter #(.XLEN(64)) dut (
      .clock_i (clock),
      .reset_i (reset_i),
      .bus_if  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [15:0] exc, input logic [63:0] pc, input logic [63:0] tval,
                        input logic [2:0] irq, input logic [2:0] mie, input logic gmie);
      bus.exc_valid_i   = exc;
      bus.exc_pc_i      = pc;
      bus.exc_tval_i    = tval;
      bus.irq_i         = irq;
      bus.mie_i         = mie;
      bus.mstatus_mie_i = gmie;
   endtask

   task automatic clear_events();
      bus.exc_valid_i = 16'h0000;
      bus.irq_i       = 3'b000;
   endtask

   // One full trap: capture, accept, service, mret.
   task automatic trap_flow(input logic [15:0] exc, input logic [63:0] pc, input logic [63:0] tval,
                            input logic [2:0] irq, input logic [2:0] mie, input logic gmie,
                            input logic [63:0] exp_cause, input logic [63:0] exp_tval);
      drive(exc, pc, tval, irq, mie, gmie);
      sb_q.push_back('{exp_cause, pc, exp_tval});
      cyc();
      chk("taken_latency", {63'd0, bus.trap_taken_o}, 64'd1);
      chk("busy_present", {63'd0, bus.busy_o}, 64'd1);
      clear_events();
      bus.trap_ready_i = 1'b1;
      cyc();
      bus.trap_ready_i = 1'b0;
      chk("taken_in_service", {63'd0, bus.trap_taken_o}, 64'd0);
      chk("busy_in_service", {63'd0, bus.busy_o}, 64'd1);
      bus.mret_i = 1'b1;
      cyc();
      bus.mret_i = 1'b0;
      chk("busy_after_mret", {63'd0, bus.busy_o}, 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_taken"}, {63'd0, bus.trap_taken_o}, 64'd0);
      chk({tag, "_busy"},  {63'd0, bus.busy_o}, 64'd0);
      chk({tag, "_cause"}, bus.trap_cause_o, 64'd0);
      chk({tag, "_pc"},    bus.trap_pc_o, 64'd0);
      chk({tag, "_tval"},  bus.trap_tval_o, 64'd0);
   endtask

   // Monitor: every accepted presentation must match the oldest expected trap
   initial begin
      trap_t e;
      forever begin
         @(negedge clock);
         if (bus.trap_taken_o === 1'b1 && bus.trap_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected: got cause 0x%0h expected no trap", bus.trap_cause_o);
            end else begin
               e = sb_q.pop_front();
               chk("sb_cause", bus.trap_cause_o, e.cause);
               chk("sb_pc",    bus.trap_pc_o,    e.pc);
               chk("sb_tval",  bus.trap_tval_o,  e.tval);
            end
         end
      end
   end

   initial begin
      reset_i          = 1'b1;
      bus.trap_ready_i = 1'b0;
      bus.mret_i       = 1'b0;
      drive(16'h0004, 64'h1234, 64'h5678, 3'b111, 3'b111, 1'b1);
      cyc();
      cyc();
      reset_i = 1'b0;
      drive(16'h0000, 64'h0, 64'h0, 3'b000, 3'b000, 1'b0);
      chk_zero("reset");
      cyc();
      chk("no_capture_from_reset", {63'd0, bus.trap_taken_o}, 64'd0);

      trap_flow(16'h0004, 64'h8000_0100, 64'hDEAD, 3'b000, 3'b000, 1'b0, 64'd2, 64'hDEAD);
      trap_flow(16'h1020, 64'h8000_0104, 64'h1111, 3'b000, 3'b000, 1'b0, 64'd12, 64'h1111);
      trap_flow(16'h000C, 64'h8000_0108, 64'h2222, 3'b000, 3'b000, 1'b0, 64'd3, 64'h2222);
      trap_flow(16'h0004, 64'h8000_010C, 64'h3333, 3'b111, 3'b111, 1'b1,
                64'h8000_0000_0000_000B, 64'h0);
      trap_flow(16'h0004, 64'h8000_0110, 64'h4444, 3'b111, 3'b111, 1'b0, 64'd2, 64'h4444);
      trap_flow(16'h0000, 64'h8000_0200, 64'h5555, 3'b011, 3'b111, 1'b1,
                64'h8000_0000_0000_0003, 64'h0);
      trap_flow(16'h0000, 64'h8000_0204, 64'h6666, 3'b010, 3'b111, 1'b1,
                64'h8000_0000_0000_0007, 64'h0);
      trap_flow(16'hC400, 64'h8000_0300, 64'h7777, 3'b000, 3'b000, 1'b0, 64'd15, 64'h7777);
      trap_flow(16'h4400, 64'h8000_0304, 64'h8888, 3'b000, 3'b000, 1'b0, 64'd10, 64'h8888);

      // Masked and globally disabled interrupts, plus mret while idle
      drive(16'h0000, 64'h0, 64'h0, 3'b100, 3'b011, 1'b1);
      cyc();
      chk("masked_irq_taken", {63'd0, bus.trap_taken_o}, 64'd0);
      drive(16'h0000, 64'h0, 64'h0, 3'b111, 3'b111, 1'b0);
      cyc();
      chk("gmie_off_taken", {63'd0, bus.trap_taken_o}, 64'd0);
      clear_events();
      bus.mret_i = 1'b1;
      cyc();
      bus.mret_i = 1'b0;
      chk("mret_idle_busy", {63'd0, bus.busy_o}, 64'd0);

      // Held presentation while inputs churn
      drive(16'h0100, 64'hAAAA_0000, 64'hBBBB, 3'b000, 3'b000, 1'b0);
      sb_q.push_back('{64'd8, 64'hAAAA_0000, 64'hBBBB});
      cyc();
      for (int i = 0; i < 5; i++) begin
         drive(16'h0001 << i, 64'h100 + 64'(i), 64'h200 + 64'(i), 3'b111, 3'b111, 1'b1);
         bus.mret_i = 1'b1;
         cyc();
         chk("hold_taken", {63'd0, bus.trap_taken_o}, 64'd1);
         chk("hold_cause", bus.trap_cause_o, 64'd8);
         chk("hold_pc",    bus.trap_pc_o, 64'hAAAA_0000);
         chk("hold_tval",  bus.trap_tval_o, 64'hBBBB);
      end
      bus.mret_i = 1'b0;
      clear_events();
      bus.trap_ready_i = 1'b1;
      cyc();
      bus.trap_ready_i = 1'b0;
      drive(16'h0004, 64'hCCCC_0000, 64'hDDDD, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("svc_ignore_taken", {63'd0, bus.trap_taken_o}, 64'd0);
         chk("svc_busy", {63'd0, bus.busy_o}, 64'd1);
      end
      bus.mret_i = 1'b1;
      sb_q.push_back('{64'd2, 64'hCCCC_0000, 64'hDDDD});
      cyc();
      bus.mret_i = 1'b0;
      chk("mret_idle_taken", {63'd0, bus.trap_taken_o}, 64'd0);
      chk("mret_idle_busy2", {63'd0, bus.busy_o}, 64'd0);
      cyc();
      chk("recapture_taken", {63'd0, bus.trap_taken_o}, 64'd1);
      clear_events();
      bus.trap_ready_i = 1'b1;
      cyc();
      bus.trap_ready_i = 1'b0;
      bus.mret_i = 1'b1;
      cyc();
      bus.mret_i = 1'b0;

      // Reset while in service
      drive(16'h0004, 64'hE000, 64'hE1, 3'b000, 3'b000, 1'b0);
      sb_q.push_back('{64'd2, 64'hE000, 64'hE1});
      cyc();
      clear_events();
      bus.trap_ready_i = 1'b1;
      cyc();
      bus.trap_ready_i = 1'b0;
      reset_i = 1'b1;
      drive(16'h0008, 64'hF000, 64'hF1, 3'b000, 3'b000, 1'b0);
      cyc();
      reset_i = 1'b0;
      clear_events();
      chk_zero("rst_svc");
      cyc();
      chk("rst_svc_no_capture", {63'd0, bus.trap_taken_o}, 64'd0);

      // Reset while presenting
      drive(16'h0002, 64'hE100, 64'hE2, 3'b000, 3'b000, 1'b0);
      cyc();
      chk("pre_rst_taken", {63'd0, bus.trap_taken_o}, 64'd1);
      reset_i = 1'b1;
      cyc();
      reset_i = 1'b0;
      clear_events();
      chk_zero("rst_present");

      cyc();
      cyc();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/trap_arbiter.md
TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of cause/pc/tval.
REQ-002 SHALL have port clock_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port exc_valid_i  input  16  synchronous exception flags from commit stage, bit n = mcause exception code n.
REQ-005 SHALL have port exc_pc_i  input  XLEN  PC of the faulting/committing instruction.
REQ-006 SHALL have port exc_tval_i  input  XLEN  trap value accompanying the exception.
REQ-007 SHALL have port irq_i  input  3  pending interrupts {meip, mtip, msip}.
REQ-008 SHALL have port mie_i  input  3  per-interrupt enables {meie, mtie, msie}.
REQ-009 SHALL have port mstatus_mie_i  input  1  global machine interrupt enable.
REQ-010 SHALL have port trap_ready_i  input  1  exception handler accepts the presented trap.
REQ-011 SHALL have port mret_i  input  1  handler has executed mret; trap service complete.
REQ-012 SHALL have port trap_taken_o  output  1  trap presented to exception handler (valid).
REQ-013 SHALL have port trap_cause_o  output  XLEN  mcause value; bit XLEN-1 = interrupt flag.
REQ-014 SHALL have port trap_pc_o  output  XLEN  mepc value to save.
REQ-015 SHALL have port trap_tval_o  output  XLEN  mtval value (zero for interrupts).
REQ-016 SHALL have port busy_o  output  1  a trap is pending or in service; commit stage must stall new exceptions.

Function
REQ-017 SHALL implement FSM states IDLE, PRESENT, IN_SERVICE.
REQ-018 IDLE: when any enabled interrupt or any exc_valid_i bit is set, SHALL register cause/pc/tval and enter PRESENT next cycle; otherwise stay IDLE.
REQ-019 Enabled interrupt = irq_i & mie_i, qualified by mstatus_mie_i; SHALL be ignored entirely when mstatus_mie_i=0.
REQ-020 Interrupt priority SHALL be MEI (cause 11) > MSI (3) > MTI (7).
REQ-021 When an enabled interrupt and an exception occur in the same cycle, the interrupt SHALL win; the exception is dropped (commit stage re-executes).
REQ-022 Exception priority, highest first: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5; remaining codes (10, 14) lowest, lower code first.
REQ-023 Interrupt trap: trap_cause_o = {1'b1, zero-extended code}, trap_tval_o = 0; exception trap: cause MSB = 0, tval = exc_tval_i.
REQ-024 trap_pc_o SHALL equal exc_pc_i sampled in the capture cycle for both trap kinds.
REQ-025 PRESENT: trap_taken_o=1 and cause/pc/tval held stable until trap_ready_i=1; on trap_ready_i=1 enter IN_SERVICE next cycle.
REQ-026 IN_SERVICE: trap_taken_o=0; SHALL ignore all new exceptions and interrupts; on mret_i=1 return to IDLE next cycle.
REQ-027 Capture latency SHALL be exactly one cycle: event in cycle N -> trap_taken_o=1 in cycle N+1.
REQ-028 busy_o SHALL be 1 in PRESENT and IN_SERVICE, 0 in IDLE.
REQ-029 Inputs changing during PRESENT SHALL NOT alter registered outputs.
REQ-030 mret_i asserted outside IN_SERVICE SHALL be ignored.
REQ-031 Unreachable state encoding SHALL return to IDLE with trap_taken_o=0.

Reset
REQ-032 reset_i=1 at a rising edge SHALL force IDLE, trap_taken_o=0, busy_o=0, cause/pc/tval = 0, from any state including mid-PRESENT or mid-IN_SERVICE.
REQ-033 Events present during the reset cycle SHALL NOT be captured.

Verification
REQ-034 exc_valid_i=0x0004 (illegal), pc=0x8000_0100, tval=0xDEAD -> next cycle trap_taken_o=1, cause=2, pc=0x8000_0100, tval=0xDEAD.
REQ-035 exc_valid_i bits 5 and 12 together -> cause=12; bits 2 and 3 together -> cause=3.
REQ-036 irq_i=3'b111, mie_i=3'b111, mstatus_mie_i=1 with exc bit 2 -> cause={1,..,11}, tval=0; repeat with mstatus_mie_i=0 -> cause=2.
REQ-037 Hold trap_ready_i=0 five cycles while changing inputs -> outputs stable; ready=1 -> IN_SERVICE; new exception ignored until mret_i, then captured one cycle after IDLE.
REQ-038 reset_i=1 in IN_SERVICE -> next cycle IDLE, all outputs zero, busy_o=0.
